// File: rtl/video_gray_convert.sv
// RGB-to-gray conversion stage with frame-latched weighting mode and per-frame statistics.
// Three-stage pipeline: multiply, sum, round/saturate/binarise. No stalls.
module video_gray_convert #(
   parameter int unsigned DATA_WIDTH    = 8,
   parameter int unsigned COEF_BITS     = 8,
   parameter int unsigned PIX_CNT_WIDTH = 22,
   parameter int unsigned PIPE_LAT      = 3
) (
   input  logic                                  i_clk,
   input  logic                                  i_rst_n,
   input  logic                                  i_vs,
   input  logic                                  i_de,
   input  logic [3*DATA_WIDTH-1:0]               i_rgb,
   input  logic [2:0]                            i_mode,
   input  logic [DATA_WIDTH-1:0]                 i_threshold,
   output logic                                  o_vs,
   output logic                                  o_de,
   output logic [DATA_WIDTH-1:0]                 o_gray,
   output logic                                  o_frame_done,
   output logic [PIX_CNT_WIDTH-1:0]              o_pix_cnt,
   output logic [PIX_CNT_WIDTH+DATA_WIDTH-1:0]   o_luma_sum
);

   localparam int unsigned CW = COEF_BITS + 1;            // weight width
   localparam int unsigned PW = DATA_WIDTH + COEF_BITS + 1; // product width
   localparam int unsigned SW = PW + 2;                   // sum width, room for 3 terms + rounding
   localparam int unsigned LW = PIX_CNT_WIDTH + DATA_WIDTH; // luma sum width

   // Rescale an 8-fractional-bit weight to COEF_BITS with rounding.
   function automatic int unsigned scale_w(input int unsigned w);
      return (w * (32'd1 << COEF_BITS) + 32'd128) / 32'd256;
   endfunction

   localparam int unsigned  WAvgI = scale_w(85);
   localparam logic [CW-1:0] W601R = CW'(scale_w(77));
   localparam logic [CW-1:0] W601G = CW'(scale_w(150));
   localparam logic [CW-1:0] W601B = CW'(scale_w(29));
   localparam logic [CW-1:0] W709R = CW'(scale_w(54));
   localparam logic [CW-1:0] W709G = CW'(scale_w(183));
   localparam logic [CW-1:0] W709B = CW'(scale_w(19));
   localparam logic [CW-1:0] WAvgR = CW'(WAvgI);
   // Average puts the rounding remainder on blue so the weights sum to exactly one.
   localparam logic [CW-1:0] WAvgB = CW'((32'd1 << COEF_BITS) - 2 * WAvgI);
   localparam logic [CW-1:0] WOne  = CW'(32'd1 << COEF_BITS);
   localparam logic [SW-1:0] Half  = SW'(32'd1 << (COEF_BITS - 1));

   // ------------------------------------------------------------------
   // Frame-start detection and mode/threshold latch
   // ------------------------------------------------------------------
   logic                  vs_prev_q;
   logic [2:0]            mode_q;
   logic [DATA_WIDTH-1:0] thr_q;
   logic                  frame_start;
   logic [2:0]            mode_eff;
   logic [DATA_WIDTH-1:0] thr_eff;

   // A pixel arriving on the frame-start cycle already uses the new settings.
   assign frame_start = i_vs & ~vs_prev_q;
   assign mode_eff    = frame_start ? i_mode : mode_q;
   assign thr_eff     = frame_start ? i_threshold : thr_q;

   // Latch conversion settings once per frame on the rising edge of i_vs.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         vs_prev_q <= 1'b0;
         mode_q    <= 3'd0;
         thr_q     <= {1'b1, {(DATA_WIDTH-1){1'b0}}};
      end else begin
         vs_prev_q <= i_vs;
         if (frame_start) begin
            mode_q <= i_mode;
            thr_q  <= i_threshold;
         end
      end
   end

   // ------------------------------------------------------------------
   // Weight selection
   // ------------------------------------------------------------------
   logic [CW-1:0] w_r, w_g, w_b;
   logic          bin_eff;

   assign bin_eff = (mode_eff == 3'd6);

   // Map the active mode to (R,G,B) weights; binarise and reserved use BT.601.
   always_comb begin
      w_r = W601R;
      w_g = W601G;
      w_b = W601B;
      case (mode_eff)
         3'd1: begin
            w_r = W709R;
            w_g = W709G;
            w_b = W709B;
         end
         3'd2: begin
            w_r = WAvgR;
            w_g = WAvgR;
            w_b = WAvgB;
         end
         3'd3: begin
            w_r = WOne;
            w_g = '0;
            w_b = '0;
         end
         3'd4: begin
            w_r = '0;
            w_g = WOne;
            w_b = '0;
         end
         3'd5: begin
            w_r = '0;
            w_g = '0;
            w_b = WOne;
         end
         default: ;
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath pipeline
   // ------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] pix_r, pix_g, pix_b;
   logic [PW-1:0]         prod_r_d, prod_g_d, prod_b_d;
   logic [PW-1:0]         prod_r_q, prod_g_q, prod_b_q;
   logic                  bin_s1_q, bin_s2_q;
   logic [DATA_WIDTH-1:0] thr_s1_q, thr_s2_q;
   logic [SW-1:0]         sum_d, sum_q;
   logic [SW-1:0]         rnd, shifted;
   logic [DATA_WIDTH-1:0] gray_sat, gray_d;
   logic [PIPE_LAT-1:0]   vs_sr_q, de_sr_q;

   assign pix_r = i_rgb[3*DATA_WIDTH-1:2*DATA_WIDTH];
   assign pix_g = i_rgb[2*DATA_WIDTH-1:DATA_WIDTH];
   assign pix_b = i_rgb[DATA_WIDTH-1:0];

   // Stage 1 products and stage 2 sum, zero-extended to full width.
   always_comb begin
      prod_r_d = {{CW{1'b0}}, pix_r} * {{DATA_WIDTH{1'b0}}, w_r};
      prod_g_d = {{CW{1'b0}}, pix_g} * {{DATA_WIDTH{1'b0}}, w_g};
      prod_b_d = {{CW{1'b0}}, pix_b} * {{DATA_WIDTH{1'b0}}, w_b};
      sum_d    = {2'b00, prod_r_q} + {2'b00, prod_g_q} + {2'b00, prod_b_q};
   end

   // Stage 3: round to nearest, saturate, then optional threshold compare.
   always_comb begin
      rnd     = sum_q + Half;
      shifted = rnd >> COEF_BITS;
      if (|shifted[SW-1:DATA_WIDTH]) begin
         gray_sat = '1;
      end else begin
         gray_sat = shifted[DATA_WIDTH-1:0];
      end
      gray_d = gray_sat;
      if (bin_s2_q) begin
         gray_d = (gray_sat >= thr_s2_q) ? '1 : '0;
      end
   end

   // Pipeline registers; sync flags travel in lock-step with the data.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         prod_r_q <= '0;
         prod_g_q <= '0;
         prod_b_q <= '0;
         bin_s1_q <= 1'b0;
         thr_s1_q <= '0;
         sum_q    <= '0;
         bin_s2_q <= 1'b0;
         thr_s2_q <= '0;
         vs_sr_q  <= '0;
         de_sr_q  <= '0;
         o_gray   <= '0;
      end else begin
         prod_r_q <= prod_r_d;
         prod_g_q <= prod_g_d;
         prod_b_q <= prod_b_d;
         bin_s1_q <= bin_eff;
         thr_s1_q <= thr_eff;
         sum_q    <= sum_d;
         bin_s2_q <= bin_s1_q;
         thr_s2_q <= thr_s1_q;
         vs_sr_q  <= {vs_sr_q[PIPE_LAT-2:0], i_vs};
         de_sr_q  <= {de_sr_q[PIPE_LAT-2:0], i_de};
         o_gray   <= de_sr_q[PIPE_LAT-2] ? gray_d : '0;
      end
   end

   assign o_vs = vs_sr_q[PIPE_LAT-1];
   assign o_de = de_sr_q[PIPE_LAT-1];

   // ------------------------------------------------------------------
   // Per-frame statistics on the output side
   // ------------------------------------------------------------------
   logic                     vs_out_prev_q;
   logic                     armed_q, armed_d;
   logic [PIX_CNT_WIDTH-1:0] pix_acc_q, pix_acc_d;
   logic [LW-1:0]            sum_acc_q, sum_acc_d;
   logic                     done_d;
   logic [PIX_CNT_WIDTH-1:0] pix_cnt_d;
   logic [LW-1:0]            luma_sum_d;
   logic [LW-1:0]            gray_ext;
   logic [LW:0]              sum_carry;
   logic                     out_rise;

   assign out_rise  = o_vs & ~vs_out_prev_q;
   assign gray_ext  = {{PIX_CNT_WIDTH{1'b0}}, o_gray};
   assign sum_carry = {1'b0, sum_acc_q} + {1'b0, gray_ext};

   // Accumulate with saturation; publish and restart on each output frame start.
   // armed_q stays low until the first frame start after reset, so a frame cut
   // short by reset never reports statistics.
   always_comb begin
      pix_acc_d  = pix_acc_q;
      sum_acc_d  = sum_acc_q;
      armed_d    = armed_q;
      done_d     = 1'b0;
      pix_cnt_d  = o_pix_cnt;
      luma_sum_d = o_luma_sum;
      if (out_rise) begin
         armed_d   = 1'b1;
         pix_acc_d = o_de ? PIX_CNT_WIDTH'(1) : '0;
         sum_acc_d = o_de ? gray_ext : '0;
         if (armed_q && (pix_acc_q != '0)) begin
            done_d     = 1'b1;
            pix_cnt_d  = pix_acc_q;
            luma_sum_d = sum_acc_q;
         end
      end else if (o_de) begin
         if (!(&pix_acc_q)) begin
            pix_acc_d = pix_acc_q + 1'b1;
         end
         sum_acc_d = sum_carry[LW] ? '1 : sum_carry[LW-1:0];
      end
   end

   // Statistics state and held result registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         vs_out_prev_q <= 1'b0;
         armed_q       <= 1'b0;
         pix_acc_q     <= '0;
         sum_acc_q     <= '0;
         o_frame_done  <= 1'b0;
         o_pix_cnt     <= '0;
         o_luma_sum    <= '0;
      end else begin
         vs_out_prev_q <= o_vs;
         armed_q       <= armed_d;
         pix_acc_q     <= pix_acc_d;
         sum_acc_q     <= sum_acc_d;
         o_frame_done  <= done_d;
         o_pix_cnt     <= pix_cnt_d;
         o_luma_sum    <= luma_sum_d;
      end
   end

endmodule
